// File: rtl/intc_v1_pkg.sv
// Shared types and constants for the intc_v1 interrupt controller.
package intc_v1_pkg;

  localparam int INTC_N_SRC = 18;
  localparam int INTC_IDW   = $clog2(INTC_N_SRC);

  localparam int INTC_EN_OFS   = 0;
  localparam int INTC_FLG_OFS  = 4;
  localparam int INTC_STAT_OFS = 8;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACTIVE
  } intc_state_t;

  typedef struct packed {
    logic                     gie;
    logic [30-INTC_N_SRC:0]   rsvd;
    logic [INTC_N_SRC-1:0]    en;
  } intc_en_t;

  typedef struct packed {
    logic                     active;
    logic [30-INTC_IDW:0]     rsvd;
    logic [INTC_IDW-1:0]      id;
  } intc_stat_t;

endpackage

// File: rtl/intc_v1_if.sv
// SFR bus and CPU interrupt handshake bundle for intc_v1.
interface intc_v1_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDW        = 5
) ();

  logic [ADDR_WIDTH-1:0] sys_addr;
  logic                  sys_wr_en;
  logic [DATA_WIDTH-1:0] sys_sw_value;
  logic [DATA_WIDTH-1:0] sfr_rd_dout;
  logic                  irq_req;
  logic                  irq_ack;
  logic [IDW-1:0]        irq_id;

  modport master (
    output sys_addr, sys_wr_en, sys_sw_value, irq_ack,
    input  sfr_rd_dout, irq_req, irq_id
  );

  modport slave (
    input  sys_addr, sys_wr_en, sys_sw_value, irq_ack,
    output sfr_rd_dout, irq_req, irq_id
  );

endinterface

// File: rtl/intc_v1_prio_enc.sv
// Priority encoder picking the winning pending source.
// INTC_PRIO_ROTATE_EN selects round-robin search from 'start'; otherwise lowest index wins.
module intc_prio_enc #(
  parameter int N_SRC = 18,
  parameter int IDW   = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] pend,
  input  logic [IDW-1:0]   start,
  output logic [IDW-1:0]   winner,
  output logic             valid
);

`ifdef INTC_PRIO_ROTATE_EN
  logic [IDW:0] idx;

  // Walk all sources starting at 'start', wrapping modulo N_SRC.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = {1'b0, start} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(N_SRC)) idx = idx - (IDW+1)'(N_SRC);
      if (!valid && pend[idx[IDW-1:0]]) begin
        valid  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end
`else
  logic unused_start;
  assign unused_start = ^start;

  always_comb begin
    winner = '0;
    valid  = |pend;
    for (int i = N_SRC-1; i >= 0; i--) begin
      if (pend[i]) winner = IDW'(i);
    end
  end
`endif

endmodule

// File: rtl/intc_v1.sv
// Interrupt controller: event flags, enables, arbitration and req/ack/EOI handshake.
// Optional INTC_PRIO_ROTATE_EN macro enables round-robin arbitration.
module intc_v1
  import intc_v1_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFF_F864,
  parameter int                    N_SRC      = INTC_N_SRC
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [N_SRC-1:0] evt_in,
  intc_v1_if.slave         bus
);

  localparam int IDW = $clog2(N_SRC);
  localparam logic [ADDR_WIDTH-1:0] EN_ADDR   = BASE_ADDR + ADDR_WIDTH'(INTC_EN_OFS);
  localparam logic [ADDR_WIDTH-1:0] FLG_ADDR  = BASE_ADDR + ADDR_WIDTH'(INTC_FLG_OFS);
  localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = BASE_ADDR + ADDR_WIDTH'(INTC_STAT_OFS);

  logic [N_SRC-1:0] en_reg;
  logic             gie_reg;
  logic [N_SRC-1:0] flg_reg;
  logic [N_SRC-1:0] flg_next;
  logic [N_SRC-1:0] evt_q_reg;
  intc_state_t      state_reg;
  logic [IDW-1:0]   id_reg;
  logic             irq_req_reg;
  logic [IDW-1:0]   irq_id_reg;

  logic sel_en, sel_flg, sel_stat;
  logic ack_fire, eoi;
  logic [N_SRC-1:0] rise, w1c_mask, ack_clr, pend;
  logic [IDW-1:0]   start_idx, enc_id;
  logic             enc_valid;
  intc_en_t         en_word;
  intc_stat_t       stat_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic             unused_wdata;

  assign sel_en   = (bus.sys_addr == EN_ADDR);
  assign sel_flg  = (bus.sys_addr == FLG_ADDR);
  assign sel_stat = (bus.sys_addr == STAT_ADDR);

  assign unused_wdata = ^bus.sys_sw_value[DATA_WIDTH-2:N_SRC];

  assign ack_fire = (state_reg == PEND) && bus.irq_ack;
  assign eoi      = bus.sys_wr_en && sel_stat;
  assign rise     = evt_in & ~evt_q_reg;
  assign w1c_mask = (bus.sys_wr_en && sel_flg) ? bus.sys_sw_value[N_SRC-1:0] : '0;
  assign ack_clr  = ack_fire ? (N_SRC'(1) << id_reg) : '0;
  // Hardware set is OR-ed in last so it beats any clear in the same cycle.
  assign flg_next = (flg_reg & ~w1c_mask & ~ack_clr) | rise;
  assign pend     = flg_reg & en_reg & {N_SRC{gie_reg}};

`ifdef INTC_PRIO_ROTATE_EN
  logic [IDW-1:0] last_ack_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    last_ack_reg <= IDW'(N_SRC-1);
    else if (ack_fire) last_ack_reg <= id_reg;
  end

  assign start_idx = (last_ack_reg == IDW'(N_SRC-1)) ? '0 : last_ack_reg + 1'b1;
`else
  assign start_idx = '0;
`endif

  intc_prio_enc #(.N_SRC(N_SRC), .IDW(IDW)) u_prio_enc (
    .pend   (pend),
    .start  (start_idx),
    .winner (enc_id),
    .valid  (enc_valid)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_reg    <= '0;
      gie_reg   <= 1'b0;
      flg_reg   <= '0;
      evt_q_reg <= '0;
    end else begin
      evt_q_reg <= evt_in;
      flg_reg   <= flg_next;
      if (bus.sys_wr_en && sel_en) begin
        en_reg  <= bus.sys_sw_value[N_SRC-1:0];
        gie_reg <= bus.sys_sw_value[DATA_WIDTH-1];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg   <= IDLE;
      id_reg      <= '0;
      irq_req_reg <= 1'b0;
      irq_id_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: if (enc_valid) begin
          state_reg   <= PEND;
          id_reg      <= enc_id;
          irq_req_reg <= 1'b1;
          irq_id_reg  <= enc_id;
        end
        PEND: if (ack_fire) begin
          state_reg   <= ACTIVE;
          irq_req_reg <= 1'b0;
          irq_id_reg  <= '0;
        end else if (!pend[id_reg]) begin
          // Request no longer backed by an enabled flag: withdraw it.
          state_reg   <= IDLE;
          id_reg      <= '0;
          irq_req_reg <= 1'b0;
          irq_id_reg  <= '0;
        end
        ACTIVE: if (eoi) begin
          state_reg <= IDLE;
          id_reg    <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    en_word        = '0;
    en_word.gie    = gie_reg;
    en_word.en     = en_reg;
    stat_word      = '0;
    stat_word.active = (state_reg == ACTIVE);
    stat_word.id   = id_reg;
    rd_data        = '0;
    if (sel_en)        rd_data = DATA_WIDTH'(en_word);
    else if (sel_flg)  rd_data[N_SRC-1:0] = flg_reg;
    else if (sel_stat) rd_data = DATA_WIDTH'(stat_word);
  end

  assign bus.sfr_rd_dout = rd_data;
  assign bus.irq_req     = irq_req_reg;
  assign bus.irq_id      = irq_id_reg;

endmodule

// File: tb/tb_intc_v1.sv
// Directed table-driven bench for intc_v1 plus a hand-written async reset sequence.
module tb_intc_v1;

  localparam logic [31:0] BASE = 32'hFFFF_F864;
  localparam int S_EN = 0, S_FLG = 1, S_STAT = 2, S_NONE = 3;
`ifdef INTC_PRIO_ROTATE_EN
  localparam int FIRST = 9, SECOND = 5;
`else
  localparam int FIRST = 5, SECOND = 9;
`endif
  localparam logic [31:0] FLG_AFTER1 = (FIRST == 9) ? 32'h20 : 32'h200;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [17:0] evt_in = '0;

  intc_v1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IDW(5)) bus ();

  intc_v1 #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .N_SRC(18)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .evt_in    (evt_in),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          wr;
    int          wsel;
    logic [31:0] wdata;
    logic [17:0] evt;
    bit          ack;
    int          rsel;
    logic [31:0] exp_rd;
    bit          exp_req;
    logic [4:0]  exp_id;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [31:0] sel_addr(int s);
    case (s)
      S_EN:    return BASE;
      S_FLG:   return BASE + 32'd4;
      S_STAT:  return BASE + 32'd8;
      default: return 32'h0000_1000;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push(input bit wr, input int wsel, input logic [31:0] wdata,
                      input logic [17:0] evt, input bit ack, input int rsel,
                      input logic [31:0] exp_rd, input bit req, input logic [4:0] id);
    vec_t v;
    v.wr = wr; v.wsel = wsel; v.wdata = wdata; v.evt = evt; v.ack = ack;
    v.rsel = rsel; v.exp_rd = exp_rd; v.exp_req = req; v.exp_id = id;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int n);
    bus.sys_wr_en    = v.wr;
    if (v.wr) bus.sys_addr = sel_addr(v.wsel);
    bus.sys_sw_value = v.wdata;
    bus.irq_ack      = v.ack;
    evt_in           = v.evt;
    @(posedge sys_clk);
    #1;
    bus.sys_wr_en    = 1'b0;
    bus.irq_ack      = 1'b0;
    bus.sys_sw_value = '0;
    bus.sys_addr     = sel_addr(v.rsel);
    #1;
    n_vec++;
    $display("vec %0d: rd=0x%08h req=%0b id=%0d", n, bus.sfr_rd_dout, bus.irq_req, bus.irq_id);
    check($sformatf("v%0d.rd", n),  bus.sfr_rd_dout, v.exp_rd);
    check($sformatf("v%0d.req", n), 32'(bus.irq_req), 32'(v.exp_req));
    check($sformatf("v%0d.id", n),  32'(bus.irq_id),  32'(v.exp_id));
  endtask

  task automatic read_check(input string nm, input int rsel, input logic [31:0] exp);
    bus.sys_addr = sel_addr(rsel);
    #1;
    n_vec++;
    $display("%s: rd=0x%08h req=%0b id=%0d", nm, bus.sfr_rd_dout, bus.irq_req, bus.irq_id);
    check({nm, ".rd"},  bus.sfr_rd_dout, exp);
    check({nm, ".req"}, 32'(bus.irq_req), 32'd0);
    check({nm, ".id"},  32'(bus.irq_id),  32'd0);
  endtask

  initial begin
    int phase1_end;

    bus.sys_addr     = sel_addr(S_NONE);
    bus.sys_wr_en    = 1'b0;
    bus.sys_sw_value = '0;
    bus.irq_ack      = 1'b0;

    // Single pulse on source 2, ack, EOI
    push(1, S_EN, 32'h8000_0004, 18'h0, 0, S_EN,   32'h8000_0004, 0, 0);
    push(0, S_EN, 32'h0,         18'h4, 0, S_FLG,  32'h4,         0, 0);
    push(0, S_EN, 32'h0,         18'h0, 0, S_FLG,  32'h4,         1, 2);
    push(0, S_EN, 32'h0,         18'h0, 1, S_STAT, 32'h8000_0002, 0, 0);
    push(0, S_EN, 32'h0,         18'h0, 0, S_FLG,  32'h0,         0, 0);
    push(0, S_EN, 32'h0,         18'h0, 0, S_NONE, 32'h0,         0, 0);
    push(1, S_STAT, 32'hDEAD_BEEF, 18'h0, 0, S_STAT, 32'h0,       0, 0);
    // Sources 5 and 9 simultaneously; 5+9 re-pulsed after serving 5
    push(1, S_EN, 32'h8000_0220, 18'h0,   0, S_EN,   32'h8000_0220, 0, 0);
    push(0, S_EN, 32'h0,         18'h220, 0, S_FLG,  32'h220,       0, 0);
    push(0, S_EN, 32'h0,         18'h0,   0, S_FLG,  32'h220,       1, 5);
    push(0, S_EN, 32'h0,         18'h0,   1, S_STAT, 32'h8000_0005, 0, 0);
    push(0, S_EN, 32'h0,         18'h220, 0, S_FLG,  32'h220,       0, 0);
    push(1, S_STAT, 32'h0,       18'h0,   0, S_FLG,  32'h220,       0, 0);
    push(0, S_EN, 32'h0,         18'h0,   0, S_STAT, 32'(FIRST),    1, 5'(FIRST));
    push(0, S_EN, 32'h0,         18'h0,   1, S_FLG,  FLG_AFTER1,    0, 0);
    push(1, S_STAT, 32'h0,       18'h0,   0, S_FLG,  FLG_AFTER1,    0, 0);
    push(0, S_EN, 32'h0,         18'h0,   0, S_STAT, 32'(SECOND),   1, 5'(SECOND));
    push(0, S_EN, 32'h0,         18'h0,   1, S_STAT, 32'h8000_0000 | 32'(SECOND), 0, 0);
    push(1, S_STAT, 32'h0,       18'h0,   0, S_STAT, 32'h0,         0, 0);
    // Held event with GIE=0, then GIE=1
    push(1, S_EN, 32'h1, 18'h0, 0, S_EN, 32'h1, 0, 0);
    for (int i = 0; i < 10; i++) push(0, S_EN, 32'h0, 18'h1, 0, S_FLG, 32'h1, 0, 0);
    push(1, S_EN, 32'h8000_0001, 18'h0, 0, S_FLG,  32'h1, 0, 0);
    push(0, S_EN, 32'h0,         18'h0, 0, S_FLG,  32'h1, 1, 0);
    push(0, S_EN, 32'h0,         18'h0, 1, S_FLG,  32'h0, 0, 0);
    push(1, S_STAT, 32'h0,       18'h0, 0, S_STAT, 32'h0, 0, 0);
    // W1C withdraw in PEND, set-beats-clear, ack+W1C, ack outside PEND
    push(1, S_EN, 32'h8000_0008, 18'h0, 0, S_EN,   32'h8000_0008, 0, 0);
    push(0, S_EN, 32'h0,         18'h8, 0, S_FLG,  32'h8,         0, 0);
    push(0, S_EN, 32'h0,         18'h0, 0, S_FLG,  32'h8,         1, 3);
    push(1, S_FLG, 32'h8,        18'h0, 0, S_FLG,  32'h0,         1, 3);
    push(0, S_EN, 32'h0,         18'h0, 0, S_STAT, 32'h0,         0, 0);
    push(0, S_EN, 32'h0,         18'h8, 0, S_FLG,  32'h8,         0, 0);
    push(0, S_EN, 32'h0,         18'h0, 0, S_FLG,  32'h8,         1, 3);
    push(1, S_FLG, 32'h8,        18'h8, 0, S_FLG,  32'h8,         1, 3);
    push(0, S_EN, 32'h0,         18'h0, 0, S_FLG,  32'h8,         1, 3);
    push(1, S_FLG, 32'h8,        18'h0, 1, S_STAT, 32'h8000_0003, 0, 0);
    push(0, S_EN, 32'h0,         18'h0, 1, S_STAT, 32'h8000_0003, 0, 0);
    push(0, S_EN, 32'h0,         18'h1, 0, S_FLG,  32'h1,         0, 0);
    phase1_end = tbl.size();
    // After async reset: quiet, then a fresh enabled event, then GIE drop
    push(0, S_EN, 32'h0,         18'h0, 0, S_STAT, 32'h0,         0, 0);
    push(0, S_EN, 32'h0,         18'h0, 0, S_FLG,  32'h0,         0, 0);
    push(1, S_EN, 32'h8000_0001, 18'h0, 0, S_EN,   32'h8000_0001, 0, 0);
    push(0, S_EN, 32'h0,         18'h1, 0, S_FLG,  32'h1,         0, 0);
    push(0, S_EN, 32'h0,         18'h0, 0, S_STAT, 32'h0,         1, 0);
    push(1, S_EN, 32'h1,         18'h0, 0, S_EN,   32'h1,         1, 0);
    push(0, S_EN, 32'h0,         18'h0, 0, S_FLG,  32'h1,         0, 0);

    // Reset values while held in reset
    #1;
    read_check("rst.none", S_NONE, 32'h0);
    read_check("rst.en",   S_EN,   32'h0);
    read_check("rst.flg",  S_FLG,  32'h0);
    read_check("rst.stat", S_STAT, 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    for (int i = 0; i < phase1_end; i++) apply(tbl[i], i);

    // Async reset mid-cycle while ACTIVE with a flag pending
    #2;
    sys_rst_n = 1'b0;
    #1;
    read_check("arst.en",   S_EN,   32'h0);
    read_check("arst.flg",  S_FLG,  32'h0);
    read_check("arst.stat", S_STAT, 32'h0);
    evt_in = '0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    for (int i = phase1_end; i < tbl.size(); i++) apply(tbl[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
